// File: rtl/jt900h_prefetch_pkg.sv
// Shared definitions for the jt900h instruction prefetcher: fetch FSM states,
// default queue geometry and the alignment rule for one bus word.
package jt900h_prefetch_pkg;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_REQ     = 2'd1,
    PF_DISCARD = 2'd2
  } pf_state_e;

  localparam int PF_QDEPTH = 8;
  localparam int PF_AW     = 24;

  // An odd fetch address only keeps the upper byte of the word, which realigns fa.
  function automatic logic [1:0] pf_word_bytes(input logic odd);
    return odd ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/jt900h_prefetch_if.sv
// Word-wide instruction memory read bus between the prefetcher and memory.
interface jt900h_prefetch_if #(
  parameter int AW = 24
) ();

  logic          bus_rd;
  logic [AW-2:0] bus_addr;
  logic [15:0]   bus_din;
  logic          bus_ok;

  modport master (output bus_rd, output bus_addr, input bus_din, input bus_ok);
  modport slave  (input bus_rd, input bus_addr, output bus_din, output bus_ok);

endinterface

// File: rtl/jt900h_pfq.sv
// Byte FIFO for the prefetcher: up to two pushes and one pop per cycle, plus flush.
module jt900h_pfq #(
  parameter int QDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic                     flush,
  input  logic [1:0]               push_n,
  input  logic [7:0]               push_b0,
  input  logic [7:0]               push_b1,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [QDEPTH];
  logic [7:0]    mem_d [QDEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_n != 2'd0) mem_d[wr_q] = push_b0;
      if (push_n == 2'd2) mem_d[wr_q + PW'(1)] = push_b1;
      wr_d  = wr_q + PW'(push_n);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + CW'(push_n) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (cen) begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/jt900h_prefetch.sv
// Instruction prefetch queue feeding the jt900h sequencer: fetches words ahead of
// the PC, presents the head byte on md and flushes on PC loads.
module jt900h_prefetch
  import jt900h_prefetch_pkg::*;
#(
  parameter int QDEPTH = PF_QDEPTH,
  parameter int AW     = PF_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic                     ld_pc,
  input  logic [AW-1:0]            pc_din,
  input  logic                     inc_pc,
  output logic [7:0]               md,
  output logic                     md_ok,
  output logic [AW-1:0]            pc,
  output logic                     fetch_busy,
  jt900h_prefetch_if.master        bus
);

  localparam int CW = $clog2(QDEPTH) + 1;

  pf_state_e     st_q, st_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          bus_rd_q, bus_rd_d;
  logic [AW-2:0] bus_addr_q, bus_addr_d;

  logic          flush;
  logic          pop;
  logic [1:0]    push_n;
  logic [7:0]    push_b0;
  logic [7:0]    push_b1;
  logic [CW-1:0] count;
  logic [CW-1:0] free;

  assign free = CW'(QDEPTH) - count;

  always_comb begin
    st_d       = st_q;
    fa_d       = fa_q;
    pc_d       = pc_q;
    bus_rd_d   = bus_rd_q;
    bus_addr_d = bus_addr_q;
    flush      = 1'b0;
    pop        = 1'b0;
    push_n     = 2'd0;
    push_b0    = bus.bus_din[7:0];
    push_b1    = bus.bus_din[15:8];
    if (ld_pc) begin
      // The bus cannot abort, so an open request is drained in DISCARD
      flush = 1'b1;
      pc_d  = pc_din;
      fa_d  = pc_din;
      case (st_q)
        PF_REQ, PF_DISCARD: begin
          if (bus.bus_ok) begin
            st_d     = PF_IDLE;
            bus_rd_d = 1'b0;
          end else begin
            st_d = PF_DISCARD;
          end
        end
        default: st_d = PF_IDLE;
      endcase
    end else begin
      if (inc_pc && md_ok) begin
        pop  = 1'b1;
        pc_d = pc_q + AW'(1);
      end
      case (st_q)
        PF_IDLE: begin
          if (free >= CW'(2)) begin
            bus_rd_d   = 1'b1;
            bus_addr_d = fa_q[AW-1:1];
            st_d       = PF_REQ;
          end
        end
        PF_REQ: begin
          if (bus.bus_ok) begin
            bus_rd_d = 1'b0;
            st_d     = PF_IDLE;
            push_n   = pf_word_bytes(fa_q[0]);
            fa_d     = fa_q + AW'(pf_word_bytes(fa_q[0]));
            if (fa_q[0]) push_b0 = bus.bus_din[15:8];
          end
        end
        PF_DISCARD: begin
          if (bus.bus_ok) begin
            bus_rd_d = 1'b0;
            st_d     = PF_IDLE;
          end
        end
        default: st_d = PF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= PF_IDLE;
      fa_q       <= '0;
      pc_q       <= '0;
      bus_rd_q   <= 1'b0;
      bus_addr_q <= '0;
    end else if (cen) begin
      st_q       <= st_d;
      fa_q       <= fa_d;
      pc_q       <= pc_d;
      bus_rd_q   <= bus_rd_d;
      bus_addr_q <= bus_addr_d;
    end
  end

  jt900h_pfq #(.QDEPTH(QDEPTH)) u_pfq (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .flush   (flush),
    .push_n  (push_n),
    .push_b0 (push_b0),
    .push_b1 (push_b1),
    .pop     (pop),
    .head    (md),
    .count   (count)
  );

  assign md_ok        = (count != '0);
  assign pc           = pc_q;
  assign fetch_busy   = (inc_pc & ~md_ok) | (st_q == PF_DISCARD);
  assign bus.bus_rd   = bus_rd_q;
  assign bus.bus_addr = bus_addr_q;

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Scoreboard bench for jt900h_prefetch: a memory responder serves word reads and
// every consumed byte is compared against the byte stream expected from the last PC load.
module tb_jt900h_prefetch;

  localparam int AW     = 24;
  localparam int QDEPTH = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic          ld_pc;
  logic [AW-1:0] pc_din;
  logic          inc_pc;
  logic [7:0]    md;
  logic          md_ok;
  logic [AW-1:0] pc;
  logic          fetch_busy;

  int            total_checks = 0;
  int            pass_count   = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [AW-1:0] exp_pc;
  logic [AW-2:0] req_log[$];
  bit            disc;
  bit            cen_rand;
  int            dly_min;
  int            dly_max;
  bit            rsp_active;
  int            rsp_wait;
  logic [AW-2:0] rsp_addr;

  jt900h_prefetch_if #(.AW(AW)) bus_if ();

  jt900h_prefetch #(.QDEPTH(QDEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .ld_pc      (ld_pc),
    .pc_din     (pc_din),
    .inc_pc     (inc_pc),
    .md         (md),
    .md_ok      (md_ok),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the byte address
  function automatic logic [7:0] membyte(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = (a * 24'd40503) ^ (a >> 9);
    return t[7:0] ^ t[15:8] ^ t[23:16];
  endfunction

  function automatic logic [15:0] memWord(input logic [AW-2:0] w);
    return {membyte({w, 1'b1}), membyte({w, 1'b0})};
  endfunction

  function automatic logic [31:0] logAt(input int i);
    logic [31:0] r;
    r = 32'hxxxxxxxx;
    if (i < req_log.size()) r = 32'(req_log[i]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic printSummary();
    $display("%0d/%0d checks passed", pass_count, total_checks);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold ld_pc until it lands on an enabled edge
  task automatic loadPc(input logic [AW-1:0] a);
    bit taken;
    taken  = 1'b0;
    ld_pc  = 1'b1;
    pc_din = a;
    inc_pc = 1'b0;
    while (!taken) begin
      @(negedge clk);
      taken = cen;
      @(posedge clk);
      #1;
    end
    ld_pc  = 1'b0;
    pc_din = 24'($urandom);
    exp_pc = a;
    req_log.delete();
  endtask

  // Consume n bytes, each expected to be the next byte of the current stream
  task automatic applyStimulus(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      bit done;
      int budget;
      idle($urandom_range(0, gap_max));
      exp_q.push_back('{addr: exp_pc, data: membyte(exp_pc)});
      inc_pc = 1'b1;
      done   = 1'b0;
      budget = 0;
      while (!done) begin
        @(negedge clk);
        if (md_ok && cen) done = 1'b1;
        else if (!md_ok) checkOutput("pc_hold", pc, exp_pc);
        budget++;
        @(posedge clk);
        #1;
        if (!done && budget > 200) begin
          total_checks++;
          $display("[TB] FAIL pop_timeout: no byte after %0d cycles, expected pc 0x%0h", budget, exp_pc);
          exp_q.delete();
          inc_pc = 1'b0;
          return;
        end
      end
      inc_pc = 1'b0;
      exp_pc = exp_pc + 24'd1;
    end
  endtask

  initial begin
    cen = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cen = cen_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Memory responder: answers each request after a random delay, only on enabled cycles
  initial begin
    rsp_active     = 1'b0;
    rsp_wait       = 0;
    rsp_addr       = '0;
    bus_if.bus_ok  = 1'b0;
    bus_if.bus_din = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_if.bus_ok = 1'b0;
      if (!rst_n) begin
        rsp_active = 1'b0;
      end else if (bus_if.bus_rd) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_addr   = bus_if.bus_addr;
          rsp_wait   = $urandom_range(dly_min, dly_max);
          req_log.push_back(rsp_addr);
        end else begin
          checkOutput("bus_addr_hold", 32'(bus_if.bus_addr), 32'(rsp_addr));
        end
        if (cen) begin
          if (rsp_wait == 0) begin
            bus_if.bus_ok  = 1'b1;
            bus_if.bus_din = memWord(rsp_addr);
            rsp_active     = 1'b0;
          end else begin
            rsp_wait--;
          end
        end
      end
    end
  end

  // Monitor: checks every completed pop against the scoreboard and tracks discard stalls
  always @(negedge clk) begin
    if (!rst_n) begin
      disc = 1'b0;
    end else begin
      checkOutput("fetch_busy", 32'(fetch_busy), 32'((inc_pc && !md_ok) || disc));
      if (cen && inc_pc && md_ok && !ld_pc) begin
        if (exp_q.size() == 0) begin
          total_checks++;
          $display("[TB] FAIL unexpected_pop: md 0x%0h pc 0x%0h, required no pop", md, pc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("md", 32'(md), 32'(mon_e.data));
          checkOutput("pc", 32'(pc), 32'(mon_e.addr));
        end
      end
      if (cen) begin
        if (ld_pc && bus_if.bus_rd && !bus_if.bus_ok) disc = 1'b1;
        else if (bus_if.bus_ok) disc = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    total_checks++;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    logic [AW-1:0] a;
    rst_n    = 1'b0;
    ld_pc    = 1'b0;
    inc_pc   = 1'b0;
    pc_din   = '0;
    cen_rand = 1'b0;
    dly_min  = 0;
    dly_max  = 0;
    exp_pc   = '0;
    disc     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_md", 32'(md), 32'h0);
    checkOutput("rst_md_ok", 32'(md_ok), 32'h0);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_bus_rd", 32'(bus_if.bus_rd), 32'h0);
    checkOutput("rst_bus_addr", 32'(bus_if.bus_addr), 32'h0);
    checkOutput("rst_fetch_busy", 32'(fetch_busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] fill queue without popping");
    loadPc(24'h000100);
    idle(40);
    checkOutput("fill_reqs", req_log.size(), 4);
    checkOutput("fill_addr0", logAt(0), 32'h80);
    @(negedge clk);
    checkOutput("fill_rd_idle", 32'(bus_if.bus_rd), 32'h0);
    idle(1);
    applyStimulus(1, 0);
    idle(10);
    checkOutput("free1_reqs", req_log.size(), 4);
    applyStimulus(1, 0);
    idle(10);
    checkOutput("free2_reqs", req_log.size(), 5);
    checkOutput("free2_addr", logAt(4), 32'h84);

    $display("[TB] odd load address");
    loadPc(24'h000205);
    idle(40);
    checkOutput("odd_reqs", req_log.size(), 4);
    checkOutput("odd_addr0", logAt(0), 32'h102);
    checkOutput("odd_addr1", logAt(1), 32'h103);
    applyStimulus(9, 0);

    $display("[TB] load while a request is outstanding");
    dly_min = 6;
    dly_max = 6;
    loadPc(24'h000300);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(bus_if.bus_rd && req_log.size() > 0) && budget < 50);
    if (budget >= 50) begin
      total_checks++;
      $display("[TB] FAIL discard_setup: no request within %0d cycles", budget);
    end
    idle(1);
    loadPc(24'h001000);
    @(negedge clk);
    checkOutput("disc_busy", 32'(fetch_busy), 32'h1);
    checkOutput("disc_rd_held", 32'(bus_if.bus_rd), 32'h1);
    idle(20);
    checkOutput("disc_next_addr", logAt(0), 32'h800);
    dly_min = 0;
    dly_max = 0;
    applyStimulus(4, 1);

    $display("[TB] pop requested on empty queue");
    dly_min = 2;
    dly_max = 3;
    loadPc(24'h002000);
    applyStimulus(5, 0);

    $display("[TB] pc wrap");
    loadPc(24'hFFFFFE);
    applyStimulus(6, 1);

    $display("[TB] randomized segments");
    cen_rand = 1'b1;
    dly_min  = 0;
    dly_max  = 3;
    for (int s = 0; s < 40; s++) begin
      idle($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFF8 + 24'($urandom_range(0, 7));
      else a = 24'($urandom);
      loadPc(a);
      applyStimulus($urandom_range(0, 14), 3);
    end

    cen_rand = 1'b0;
    idle(20);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    printSummary();
    $finish;
  end

endmodule
